// File: rtl/hart_sequencer_pkg.sv
// Shared ISA types for the hart sequencer: data width, memory request
// record, write-width and sequencer state encodings.
package isa_types;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        write_byte,
        write_half,
        write_word
    } mem_width_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic            wenable;
        mem_width_t      wwidth;
    } mem_control_t;

    typedef enum logic [2:0] {
        HS_RESET,
        HS_FETCH,
        HS_LOAD,
        HS_WRITEBACK,
        HS_HALTED,
        HS_FAULT
    } hart_seq_state_t;

    typedef enum logic [1:0] {
        MSEL_NONE,
        MSEL_FETCH,
        MSEL_LOAD,
        MSEL_WB
    } mem_sel_t;

endpackage

// File: rtl/hart_sequencer_if.sv
// Stage handshake, memory and writeback bundle between the sequencer
// (master) and the stage/memory/register-file environment (slave).
interface hart_sequencer_if;
    import isa_types::*;

    logic              fetch_enable;
    logic              load_enable;
    logic              wb_enable;
    logic              fetch_complete;
    logic              load_complete;
    logic              wb_complete;
    mem_control_t      fetch_mem_ctrl;
    mem_control_t      load_mem_ctrl;
    mem_control_t      wb_mem_ctrl;
    mem_control_t      mem_ctrl;
    logic              wb_rd_enable;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_rd_val;
    logic              wb_jump_enable;
    logic [XLEN-1:0]   wb_jump_target;
    logic              halt_req;
    logic [XLEN-1:0]   pc;
    logic              rf_wenable;
    logic [4:0]        rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic [31:0]       retire_count;
    logic              halted;
    logic              fault;

    modport master (
        output fetch_enable, load_enable, wb_enable,
        input  fetch_complete, load_complete, wb_complete,
        input  fetch_mem_ctrl, load_mem_ctrl, wb_mem_ctrl,
        output mem_ctrl,
        input  wb_rd_enable, wb_rd, wb_rd_val,
        input  wb_jump_enable, wb_jump_target,
        input  halt_req,
        output pc, rf_wenable, rf_waddr, rf_wdata,
        output retire_count, halted, fault
    );

    modport slave (
        input  fetch_enable, load_enable, wb_enable,
        output fetch_complete, load_complete, wb_complete,
        output fetch_mem_ctrl, load_mem_ctrl, wb_mem_ctrl,
        input  mem_ctrl,
        output wb_rd_enable, wb_rd, wb_rd_val,
        output wb_jump_enable, wb_jump_target,
        output halt_req,
        input  pc, rf_wenable, rf_waddr, rf_wdata,
        input  retire_count, halted, fault
    );

endinterface

// File: rtl/hart_sequencer_mem_port_mux.sv
// Selects which stage owns the memory port; fetch and load are forced to
// read-only, and an idle port presents a harmless byte-width read.
module mem_port_mux
    import isa_types::*;
(
    input  mem_sel_t     sel_i,
    input  mem_control_t fetch_i,
    input  mem_control_t load_i,
    input  mem_control_t wb_i,
    output mem_control_t mem_o
);

    always_comb begin
        mem_o         = '0;
        mem_o.wenable = 1'b0;
        mem_o.wwidth  = write_byte;
        unique case (sel_i)
            MSEL_FETCH: begin
                mem_o         = fetch_i;
                mem_o.wenable = 1'b0;
            end
            MSEL_LOAD: begin
                mem_o         = load_i;
                mem_o.wenable = 1'b0;
            end
            MSEL_WB: begin
                mem_o = wb_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hart_sequencer.sv
// Multi-cycle hart control: sequences fetch/load/writeback stages, owns the
// pc and retire counter, and routes the shared memory port.
module hart_sequencer
    import isa_types::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    hart_sequencer_if.master    bus
);

    hart_seq_state_t state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     retire_q, retire_d;

    logic            wb_fire;
    logic            jump_misaligned;
    mem_sel_t        mem_sel;
    mem_control_t    mem_ctrl_w;

    logic            fetch_en_w, load_en_w, wb_en_w;
    logic            halted_w, fault_w, rf_we_w;

    assign wb_fire         = (state_q == HS_WRITEBACK) && bus.wb_complete;
    assign jump_misaligned = bus.wb_jump_enable && (bus.wb_jump_target[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= HS_RESET;
            pc_q     <= RESET_PC;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            retire_q <= retire_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        retire_d = retire_q;
        unique case (state_q)
            HS_RESET:  state_d = HS_FETCH;
            HS_FETCH:  if (bus.fetch_complete) state_d = HS_LOAD;
            HS_LOAD:   if (bus.load_complete)  state_d = HS_WRITEBACK;
            HS_WRITEBACK: begin
                if (wb_fire) begin
                    // A faulting jump still retires, but the pc keeps the faulting address.
                    retire_d = retire_q + 32'd1;
                    if (jump_misaligned) begin
                        state_d = HS_FAULT;
                    end else begin
                        pc_d    = bus.wb_jump_enable ? bus.wb_jump_target : pc_q + PC_STEP;
                        state_d = bus.halt_req ? HS_HALTED : HS_FETCH;
                    end
                end
            end
            HS_HALTED: if (!bus.halt_req) state_d = HS_FETCH;
            HS_FAULT:  state_d = HS_FAULT;
            default:   state_d = HS_RESET;
        endcase
    end

    always_comb begin
        fetch_en_w = 1'b0;
        load_en_w  = 1'b0;
        wb_en_w    = 1'b0;
        halted_w   = 1'b0;
        fault_w    = 1'b0;
        mem_sel    = MSEL_NONE;
        unique case (state_q)
            HS_FETCH: begin
                fetch_en_w = 1'b1;
                mem_sel    = MSEL_FETCH;
            end
            HS_LOAD: begin
                load_en_w = 1'b1;
                mem_sel   = MSEL_LOAD;
            end
            HS_WRITEBACK: begin
                wb_en_w = 1'b1;
                mem_sel = MSEL_WB;
            end
            HS_HALTED: halted_w = 1'b1;
            HS_FAULT:  fault_w  = 1'b1;
            default: ;
        endcase
        rf_we_w = wb_fire && bus.wb_rd_enable && (bus.wb_rd != 5'd0);
    end

    mem_port_mux u_mem_port_mux (
        .sel_i   (mem_sel),
        .fetch_i (bus.fetch_mem_ctrl),
        .load_i  (bus.load_mem_ctrl),
        .wb_i    (bus.wb_mem_ctrl),
        .mem_o   (mem_ctrl_w)
    );

    assign bus.fetch_enable = fetch_en_w;
    assign bus.load_enable  = load_en_w;
    assign bus.wb_enable    = wb_en_w;
    assign bus.halted       = halted_w;
    assign bus.fault        = fault_w;
    assign bus.mem_ctrl     = mem_ctrl_w;
    assign bus.rf_wenable   = rf_we_w;
    assign bus.rf_waddr     = bus.wb_rd;
    assign bus.rf_wdata     = bus.wb_rd_val;
    assign bus.pc           = pc_q;
    assign bus.retire_count = retire_q;

endmodule
